// File: rtl/spi_bus_bridge.sv
// spi_bus_bridge: SPI mode-0 target that turns SPI frames into PicoRV32 native-bus
// read/write transactions, acting as a second bus master.
module spi_bus_bridge #(
   parameter int unsigned TIMEOUT  = 32,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spi_sck,
   input  logic        spi_cs_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        err
);
   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDUMMY, S_RDATA, S_DISCARD} spi_state_t;
   typedef enum logic {B_IDLE, B_WAIT} bus_state_t;
   localparam logic [5:0] TLAST = 6'(TIMEOUT - 1);

   spi_state_t  state_q, state_d;
   bus_state_t  bstate_q, bstate_d;
   logic [2:0]  sck_q, cs_q;
   logic [1:0]  mosi_q;
   logic [4:0]  cnt_q, cnt_d;
   logic [30:0] sr_q, sr_d;
   logic [31:0] tx_q, tx_d, addr_q, addr_d, rdbuf_q, rdbuf_d;
   logic [31:0] maddr_q, maddr_d, wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [5:0]  tcnt_q, tcnt_d;
   logic        is_rd_q, is_rd_d, err_q, err_d;
   logic        sck_rise, sck_fall, cs_rise, cs_fall, cs_low, mosi, rise, fall;
   logic [31:0] word, addr_inc, req_addr, req_wdata;
   logic        req, req_we, start, last;

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_q  <= 3'b000;
         cs_q   <= 3'b111;
         mosi_q <= 2'b00;
      end else begin
         sck_q  <= {sck_q[1:0], spi_sck};
         cs_q   <= {cs_q[1:0], spi_cs_n};
         mosi_q <= {mosi_q[0], spi_mosi};
      end
   end

   assign sck_rise = sck_q[1] & ~sck_q[2];
   assign sck_fall = ~sck_q[1] & sck_q[2];
   assign cs_rise  = cs_q[1] & ~cs_q[2];
   assign cs_fall  = ~cs_q[1] & cs_q[2];
   assign cs_low   = ~cs_q[1];
   assign mosi     = mosi_q[1];
   // a cs rise on the same clk as an sck edge ends the frame; the edge is ignored
   assign rise     = sck_rise & ~cs_rise;
   assign fall     = sck_fall & ~cs_rise;
   assign word     = {sr_q, mosi};
   assign addr_inc = addr_q + 32'd4;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         tx_q    <= '0;
         addr_q  <= '0;
         is_rd_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         tx_q    <= tx_d;
         addr_q  <= addr_d;
         is_rd_q <= is_rd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (cs_rise) state_d = S_IDLE;
      else case (state_q)
         S_IDLE:   if (cs_fall) state_d = S_CMD;
         S_CMD:    if (rise && cnt_q == 5'd7)
            state_d = (word[7:0] == 8'h02 || word[7:0] == 8'h03) ? S_ADDR : S_DISCARD;
         S_ADDR:   if (rise && cnt_q == 5'd31) state_d = is_rd_q ? S_RDUMMY : S_WDATA;
         S_RDUMMY: if (fall && cnt_q == 5'd8) state_d = S_RDATA;
         default:  state_d = state_q;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      sr_d      = sr_q;
      tx_d      = tx_q;
      addr_d    = addr_q;
      is_rd_d   = is_rd_q;
      req       = 1'b0;
      req_we    = 1'b0;
      req_addr  = addr_inc;
      req_wdata = '0;
      if (rise && (state_q == S_CMD || state_q == S_ADDR || state_q == S_WDATA || state_q == S_RDUMMY)) begin
         cnt_d = cnt_q + 5'd1;
         sr_d  = word[30:0];
      end
      if (fall && state_q == S_RDATA) begin
         cnt_d = cnt_q + 5'd1;
         tx_d  = {tx_q[30:0], 1'b0};
      end
      if (rise && state_q == S_CMD && cnt_q == 5'd7) is_rd_d = word[7:0] == 8'h03;
      if (rise && state_q == S_ADDR && cnt_q == 5'd31) begin
         addr_d   = {word[31:2], 2'b00};
         req      = is_rd_q;
         req_addr = {word[31:2], 2'b00};
      end
      if (rise && state_q == S_WDATA && cnt_q == 5'd31) begin
         req       = 1'b1;
         req_we    = 1'b1;
         req_addr  = addr_q;
         req_wdata = word;
         addr_d    = addr_inc;
      end
      // hand the prefetched word to the shifter and fetch the next one
      if (fall && ((state_q == S_RDUMMY && cnt_q == 5'd8) || (state_q == S_RDATA && cnt_q == 5'd31))) begin
         tx_d   = rdbuf_q;
         req    = 1'b1;
         addr_d = addr_inc;
      end
      if (cs_fall) tx_d = '0;
      if (state_d != state_q) cnt_d = '0;
   end

   assign spi_miso_oe = cs_low && (state_q == S_RDUMMY || state_q == S_RDATA);
   assign spi_miso    = spi_miso_oe & tx_q[31];

   always_ff @(posedge clk) begin
      if (reset) begin
         bstate_q <= B_IDLE;
         maddr_q  <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         tcnt_q   <= '0;
         rdbuf_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         bstate_q <= bstate_d;
         maddr_q  <= maddr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         tcnt_q   <= tcnt_d;
         rdbuf_q  <= rdbuf_d;
         err_q    <= err_d;
      end
   end

   assign start = bstate_q == B_IDLE && req;
   assign last  = tcnt_q == TLAST;

   always_comb bstate_d = (bstate_q == B_IDLE) ? (req ? B_WAIT : B_IDLE)
                                               : ((mem_ready || last) ? B_IDLE : B_WAIT);

   // ready beats timeout when both land on the final wait cycle
   always_comb begin
      maddr_d = start ? req_addr : maddr_q;
      wdata_d = start ? req_wdata : wdata_q;
      wstrb_d = start ? {4{req_we}} : wstrb_q;
      tcnt_d  = start ? 6'd0 : (bstate_q == B_WAIT ? tcnt_q + 6'd1 : tcnt_q);
      rdbuf_d = (bstate_q == B_WAIT && wstrb_q == 4'h0)
                ? (mem_ready ? mem_rdata : (last ? ERR_DATA : rdbuf_q)) : rdbuf_q;
      err_d   = err_q | (bstate_q == B_WAIT && !mem_ready && last);
   end

   assign mem_valid = bstate_q == B_WAIT;
   assign mem_addr  = maddr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;
   assign busy      = cs_low | mem_valid;
   assign err       = err_q;
endmodule

// File: tb/tb_spi_bus_bridge.sv
// tb_spi_bus_bridge: directed SPI frames against a simple bus responder with
// hand-computed expected bus transactions and MISO words.
module tb_spi_bus_bridge;
   localparam int HALF = 8;
   localparam int TO   = 32;

   logic        clk = 1'b0, reset = 1'b1;
   logic        spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
   logic        spi_miso, spi_miso_oe, mem_valid, busy, err;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;

   int checks = 0, errors = 0;
   logic [7:0]  txq[$], rxq[$];
   logic [31:0] log_addr[$], log_wdata[$], rsp_data[$];
   logic [3:0]  log_wstrb[$];
   int          valid_len[$];
   bit          rsp_en = 1'b1, oe_seen = 1'b0;
   int          rsp_delay = 0;

   spi_bus_bridge #(.TIMEOUT(TO), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .busy(busy), .err(err));

   always #5 clk = ~clk;

   // bus responder and transaction monitor, driven on the falling clk edge
   initial begin
      int wait_cnt = 0, vlen = 0;
      bit prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         mem_ready = 1'b0;
         if (spi_miso_oe || spi_miso) oe_seen = 1'b1;
         if (mem_valid && !prev_valid) begin
            log_addr.push_back(mem_addr);
            log_wdata.push_back(mem_wdata);
            log_wstrb.push_back(mem_wstrb);
         end
         if (mem_valid) vlen++;
         else if (prev_valid) begin
            valid_len.push_back(vlen);
            vlen = 0;
         end
         if (mem_valid && rsp_en) begin
            if (wait_cnt == rsp_delay) begin
               mem_ready = 1'b1;
               mem_rdata = (rsp_data.size() > 0) ? rsp_data.pop_front() : 32'h0;
               wait_cnt  = 0;
            end else wait_cnt++;
         end else wait_cnt = 0;
         prev_valid = mem_valid;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [31:0] la(int i);
      return (i < log_addr.size()) ? log_addr[i] : 32'hxxxx_xxxx;
   endfunction
   function automatic logic [31:0] lw(int i);
      return (i < log_wdata.size()) ? log_wdata[i] : 32'hxxxx_xxxx;
   endfunction
   function automatic logic [3:0] ls(int i);
      return (i < log_wstrb.size()) ? log_wstrb[i] : 4'hx;
   endfunction
   function automatic int lv(int i);
      return (i < valid_len.size()) ? valid_len[i] : -1;
   endfunction
   function automatic logic [31:0] rxw(int i);
      return (i + 3 < rxq.size()) ? {rxq[i], rxq[i+1], rxq[i+2], rxq[i+3]} : 32'hxxxx_xxxx;
   endfunction

   task automatic clear_logs();
      log_addr = {}; log_wdata = {}; log_wstrb = {}; valid_len = {}; rsp_data = {};
      oe_seen = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, input bit final_bit, output logic [7:0] rx);
      rx = '0;
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = tx[i];
         repeat (HALF) @(negedge clk);
         spi_sck = 1'b1;
         rx[i] = spi_miso;
         repeat (HALF) @(negedge clk);
         if (!(final_bit && i == 0)) spi_sck = 1'b0;
      end
   endtask

   task automatic send_bytes(input bit hold_last);
      logic [7:0] r;
      rxq = {};
      spi_cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < txq.size(); i++) begin
         spi_byte(txq[i], hold_last && (i == txq.size() - 1), r);
         rxq.push_back(r);
      end
   endtask

   task automatic end_frame();
      spi_sck  = 1'b0;
      spi_cs_n = 1'b1;
      repeat (4 * HALF) @(negedge clk);
   endtask

   task automatic run_frame();
      send_bytes(1'b1);
      end_frame();
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge clk);
         done = !busy;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL wait_idle: busy still %b after 2000 cycles, expected 0", busy);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      checks++;
      if ({mem_valid, spi_miso, spi_miso_oe, busy, err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000", {mem_valid, spi_miso, spi_miso_oe, busy, err});
      end
      checks++;
      if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin
         errors++;
         $display("FAIL reset_bus: got addr %h wdata %h wstrb %h expected all 0", mem_addr, mem_wdata, mem_wstrb);
      end
   endtask

   task automatic test_write_burst();
      clear_logs(); rsp_en = 1'b1; rsp_delay = 1;
      txq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      run_frame(); wait_idle();
      checks++;
      if (log_addr.size() != 2) begin errors++; $display("FAIL wr_count: got %0d expected 2", log_addr.size()); end
      checks++;
      if ({la(0), lw(0), ls(0)} !== {32'h10, 32'h1122_3344, 4'hF}) begin
         errors++; $display("FAIL wr_word0: got %h/%h/%h expected 00000010/11223344/f", la(0), lw(0), ls(0));
      end
      checks++;
      if ({la(1), lw(1), ls(1)} !== {32'h14, 32'h5566_7788, 4'hF}) begin
         errors++; $display("FAIL wr_word1: got %h/%h/%h expected 00000014/55667788/f", la(1), lw(1), ls(1));
      end
      checks++;
      if (oe_seen !== 1'b0) begin errors++; $display("FAIL wr_oe: got %b expected 0", oe_seen); end
   endtask

   task automatic test_read();
      clear_logs(); rsp_en = 1'b1; rsp_delay = 3;
      rsp_data = '{32'hCAFE_F00D, 32'h0123_4567, 32'h89AB_CDEF};
      txq = '{8'h03, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(); wait_idle();
      checks++;
      if (rxw(6) !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_word0: got %h expected cafef00d", rxw(6)); end
      checks++;
      if (rxw(10) !== 32'h0123_4567) begin errors++; $display("FAIL rd_word1: got %h expected 01234567", rxw(10)); end
      checks++;
      if ({log_addr.size(), la(0), la(1), la(2)} !== {32'd3, 32'h100, 32'h104, 32'h108}) begin
         errors++; $display("FAIL rd_addrs: got n=%0d %h %h %h expected n=3 100 104 108", log_addr.size(), la(0), la(1), la(2));
      end
      checks++;
      if ({ls(0), ls(1), ls(2)} !== 12'h000) begin
         errors++; $display("FAIL rd_wstrb: got %h %h %h expected 0 0 0", ls(0), ls(1), ls(2));
      end
      checks++;
      if (oe_seen !== 1'b1) begin errors++; $display("FAIL rd_oe: got %b expected 1", oe_seen); end
   endtask

   task automatic test_ready_at_expiry();
      clear_logs(); rsp_en = 1'b1; rsp_delay = TO - 1;
      rsp_data = '{32'h1357_9BDF, 32'h2468_ACE0};
      txq = '{8'h03, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(); wait_idle();
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL expiry_err: got %b expected 0", err); end
      checks++;
      if (rxw(6) !== 32'h1357_9BDF) begin errors++; $display("FAIL expiry_data: got %h expected 13579bdf", rxw(6)); end
      checks++;
      if (lv(0) != TO) begin errors++; $display("FAIL expiry_len: got %0d expected %0d", lv(0), TO); end
   endtask

   task automatic test_wrap_partial();
      clear_logs(); rsp_en = 1'b1; rsp_delay = 0;
      txq = '{8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hC1, 8'hC2};
      run_frame(); wait_idle();
      checks++;
      if (log_addr.size() != 2) begin errors++; $display("FAIL wrap_count: got %0d expected 2", log_addr.size()); end
      checks++;
      if ({la(0), lw(0)} !== {32'hFFFF_FFFC, 32'hA1A2_A3A4}) begin
         errors++; $display("FAIL wrap_word0: got %h/%h expected fffffffc/a1a2a3a4", la(0), lw(0));
      end
      checks++;
      if ({la(1), lw(1)} !== {32'h0, 32'hB1B2_B3B4}) begin
         errors++; $display("FAIL wrap_word1: got %h/%h expected 00000000/b1b2b3b4", la(1), lw(1));
      end
   endtask

   task automatic test_bad_cmd();
      clear_logs(); rsp_en = 1'b1; rsp_delay = 0;
      txq = '{8'h7E, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
      run_frame(); wait_idle();
      checks++;
      if (log_addr.size() != 0) begin errors++; $display("FAIL bad_cmd_bus: got %0d accesses expected 0", log_addr.size()); end
      checks++;
      if (oe_seen !== 1'b0) begin errors++; $display("FAIL bad_cmd_oe: got %b expected 0", oe_seen); end
   endtask

   task automatic test_early_cs();
      clear_logs(); rsp_en = 1'b1; rsp_delay = 0;
      txq = '{8'h03, 8'h00, 8'h00, 8'h04};
      send_bytes(1'b1);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL early_busy: got %b expected 1", busy); end
      end_frame(); wait_idle();
      checks++;
      if ({log_addr.size(), busy, spi_miso_oe} !== {32'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL early_cs: got n=%0d busy=%b oe=%b expected 0 0 0", log_addr.size(), busy, spi_miso_oe);
      end
   endtask

   task automatic test_timeout();
      clear_logs(); rsp_en = 1'b0;
      txq = '{8'h03, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(); wait_idle();
      checks++;
      if (lv(0) != TO) begin errors++; $display("FAIL to_len: got %0d expected %0d", lv(0), TO); end
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", err); end
      checks++;
      if (rxw(6) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_data: got %h expected deadbeef", rxw(6)); end
      checks++;
      if (la(0) !== 32'h200) begin errors++; $display("FAIL to_addr: got %h expected 00000200", la(0)); end
   endtask

   task automatic test_err_sticky();
      clear_logs(); rsp_en = 1'b1; rsp_delay = 0;
      txq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h30, 8'h01, 8'h02, 8'h03, 8'h04};
      run_frame(); wait_idle();
      checks++;
      if ({err, lw(0)} !== {1'b1, 32'h0102_0304}) begin
         errors++; $display("FAIL err_sticky: got err=%b wdata=%h expected 1 01020304", err, lw(0));
      end
   endtask

   task automatic test_reset_mid_write();
      bit seen = 1'b0;
      clear_logs(); rsp_en = 1'b0;
      txq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h40, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
      send_bytes(1'b0);
      for (int i = 0; i < 100 && !seen; i++) begin
         seen = mem_valid;
         if (!seen) @(negedge clk);
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL mid_valid: mem_valid got 0 expected 1 before reset"); end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({mem_valid, busy, err, spi_miso, spi_miso_oe} !== 5'b0) begin
         errors++; $display("FAIL mid_reset: got valid/busy/err/miso/oe %b expected 00000",
                            {mem_valid, busy, err, spi_miso, spi_miso_oe});
      end
      checks++;
      if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin
         errors++; $display("FAIL mid_reset_bus: got %h/%h/%h expected all 0", mem_addr, mem_wdata, mem_wstrb);
      end
      @(negedge clk);
      spi_sck = 1'b0; spi_cs_n = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      clear_logs(); rsp_en = 1'b1; rsp_delay = 2;
      txq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h80, 8'h0B, 8'hAD, 8'hCA, 8'hFE};
      run_frame(); wait_idle();
      checks++;
      if ({log_addr.size(), la(0), lw(0), ls(0)} !== {32'd1, 32'h80, 32'h0BAD_CAFE, 4'hF}) begin
         errors++; $display("FAIL post_reset_wr: got n=%0d %h/%h/%h expected n=1 00000080/0badcafe/f",
                            log_addr.size(), la(0), lw(0), ls(0));
      end
   endtask

   initial begin
      repeat (5) @(negedge clk);
      test_reset();
      reset = 1'b0;
      repeat (5) @(negedge clk);
      test_reset();
      test_write_burst();
      test_read();
      test_ready_at_expiry();
      test_wrap_partial();
      test_bad_cmd();
      test_early_cs();
      test_timeout();
      test_err_sticky();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
